// File: rtl/adc_block_buffer.sv
// Ping-pong ADC sample buffer: collects DATA_W-bit samples into 2^BLOCK_LOG2-word
// blocks across two banks and serves complete blocks one word per rdreq.
//
// state  | meaning
// S_IDLE | capture disabled, samples ignored, write pointer held at 0
// S_FILL | capturing adc_valid samples into the current write bank
// S_PAD  | padding the partial block with PAD_WORD until the bank wraps
module adc_block_buffer #(
   parameter int                 DATA_W     = 16,
   parameter int                 BLOCK_LOG2 = 8,
   parameter logic [DATA_W-1:0]  PAD_WORD   = '0
) (
   input  logic              clock,
   input  logic              aclr,
   input  logic              start,
   input  logic [DATA_W-1:0] adc_data,
   input  logic              adc_valid,
   input  logic              flush,
   input  logic              rdreq,
   output logic [DATA_W-1:0] data_blocks,
   output logic              is_there_256,
   output logic [15:0]       frame_count,
   output logic [15:0]       dropped_count,
   output logic              overflow
);

   localparam int                    MEM_WORDS = 2 ** (BLOCK_LOG2 + 1);
   localparam logic [BLOCK_LOG2-1:0] PTR_MAX   = '1;

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_PAD} wr_state_t;

   wr_state_t              state;
   logic [1:0]             full;
   logic                   wr_bank;
   logic                   rd_bank;
   logic [BLOCK_LOG2-1:0]  wr_ptr;
   logic [BLOCK_LOG2-1:0]  rd_ptr;
   logic [DATA_W-1:0]      mem [0:MEM_WORDS-1];

   logic                   wr_full;
   logic                   wr_en;
   logic [DATA_W-1:0]      wr_data;
   logic                   wr_wrap;
   logic                   drop;
   logic                   ovf_set;
   logic                   pad_go;
   logic                   rd_fire;
   logic [1:0]             full_set;
   logic [1:0]             full_clr;

   assign wr_full = full[wr_bank];

   always_comb begin
      wr_en   = 1'b0;
      wr_data = adc_data;
      drop    = 1'b0;
      ovf_set = 1'b0;
      case (state)
         S_FILL: begin
            if (start && adc_valid) begin
               if (wr_full) begin
                  drop    = 1'b1;
                  ovf_set = 1'b1;
               end else begin
                  wr_en = 1'b1;
               end
            end
         end
         S_PAD: begin
            if (start) begin
               wr_en   = 1'b1;
               wr_data = PAD_WORD;
               drop    = adc_valid;
            end
         end
         default: ;
      endcase
   end

   assign wr_wrap = wr_en && (wr_ptr == PTR_MAX);
   assign pad_go  = (state == S_FILL) && start && flush && !wr_full
                    && (wr_ptr != '0) && !wr_wrap;

   // The extra full[rd_bank] term blocks a stray read in the one cycle where the
   // registered is_there_256 still shows the bank that was just drained.
   assign rd_fire  = rdreq && is_there_256 && full[rd_bank];
   assign full_set = wr_wrap ? (2'b01 << wr_bank) : 2'b00;
   assign full_clr = (rd_fire && (rd_ptr == PTR_MAX)) ? (2'b01 << rd_bank) : 2'b00;

   always_ff @(posedge clock) begin
      if (wr_en)
         mem[{wr_bank, wr_ptr}] <= wr_data;
   end

   always_ff @(posedge clock or posedge aclr) begin
      if (aclr) begin
         state         <= S_IDLE;
         full          <= 2'b00;
         wr_bank       <= 1'b0;
         rd_bank       <= 1'b0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         data_blocks   <= '0;
         is_there_256  <= 1'b0;
         frame_count   <= 16'd0;
         dropped_count <= 16'd0;
         overflow      <= 1'b0;
      end else begin
         full         <= (full | full_set) & ~full_clr;
         is_there_256 <= full[rd_bank];

         if (drop && (dropped_count != 16'hFFFF))
            dropped_count <= dropped_count + 16'd1;
         if (ovf_set)
            overflow <= 1'b1;

         if (rd_fire) begin
            data_blocks <= mem[{rd_bank, rd_ptr}];
            rd_ptr      <= rd_ptr + 1'b1;
            if (rd_ptr == PTR_MAX) begin
               rd_bank     <= ~rd_bank;
               frame_count <= frame_count + 16'd1;
            end
         end

         case (state)
            S_IDLE: begin
               wr_ptr <= '0;
               if (start)
                  state <= S_FILL;
            end
            S_FILL: begin
               if (!start) begin
                  state  <= S_IDLE;
                  wr_ptr <= '0;
               end else begin
                  if (wr_en) begin
                     wr_ptr <= wr_ptr + 1'b1;
                     if (wr_wrap)
                        wr_bank <= ~wr_bank;
                  end
                  if (pad_go)
                     state <= S_PAD;
               end
            end
            S_PAD: begin
               if (!start) begin
                  state  <= S_IDLE;
                  wr_ptr <= '0;
               end else begin
                  wr_ptr <= wr_ptr + 1'b1;
                  if (wr_wrap) begin
                     wr_bank <= ~wr_bank;
                     state   <= S_FILL;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adc_block_buffer.sv
// Directed bench for adc_block_buffer: capture, overflow, flush padding,
// restart discard, idle reads and asynchronous reset.
module tb_adc_block_buffer;

   logic        clock = 1'b0;
   logic        aclr;
   logic        start;
   logic [15:0] adc_data;
   logic        adc_valid;
   logic        flush;
   logic        rdreq;
   logic [15:0] data_blocks;
   logic        is_there_256;
   logic [15:0] frame_count;
   logic [15:0] dropped_count;
   logic        overflow;

   int vectors = 0;
   int errors  = 0;

   adc_block_buffer #(.DATA_W(16), .BLOCK_LOG2(8), .PAD_WORD(16'h0000)) dut (
      .clock         (clock),
      .aclr          (aclr),
      .start         (start),
      .adc_data      (adc_data),
      .adc_valid     (adc_valid),
      .flush         (flush),
      .rdreq         (rdreq),
      .data_blocks   (data_blocks),
      .is_there_256  (is_there_256),
      .frame_count   (frame_count),
      .dropped_count (dropped_count),
      .overflow      (overflow)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      aclr = 1'b1; start = 1'b0; adc_valid = 1'b0; adc_data = '0; flush = 1'b0; rdreq = 1'b0;
      step();
      aclr = 1'b0;
      step();
   endtask

   task automatic write_samples(input int base, input int n);
      for (int i = 0; i < n; i++) begin
         adc_valid = 1'b1;
         adc_data  = 16'(base + i);
         step();
      end
      adc_valid = 1'b0;
   endtask

   task automatic test_reset();
      aclr = 1'b1; start = 1'b0; adc_valid = 1'b0; adc_data = '0; flush = 1'b0; rdreq = 1'b0;
      #2;
      vectors++; if (data_blocks !== 16'd0) begin errors++; $display("FAIL reset_data got %0d expected 0", data_blocks); end
      vectors++; if (is_there_256 !== 1'b0) begin errors++; $display("FAIL reset_ready got %b expected 0", is_there_256); end
      vectors++; if (frame_count !== 16'd0) begin errors++; $display("FAIL reset_frames got %0d expected 0", frame_count); end
      vectors++; if (dropped_count !== 16'd0) begin errors++; $display("FAIL reset_dropped got %0d expected 0", dropped_count); end
      vectors++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b expected 0", overflow); end
   endtask

   task automatic test_single_block();
      do_reset();
      start = 1'b1;
      step();
      write_samples(0, 256);
      vectors++; if (is_there_256 !== 1'b0) begin errors++; $display("FAIL s1_ready_early got %b expected 0", is_there_256); end
      step();
      vectors++; if (is_there_256 !== 1'b1) begin errors++; $display("FAIL s1_ready_latency got %b expected 1", is_there_256); end
      for (int i = 0; i < 256; i++) begin
         rdreq = 1'b1;
         step();
         vectors++;
         if (data_blocks !== 16'(i)) begin errors++; $display("FAIL s1_data[%0d] got %0d expected %0d", i, data_blocks, i); end
      end
      rdreq = 1'b0;
      vectors++; if (frame_count !== 16'd1) begin errors++; $display("FAIL s1_frames got %0d expected 1", frame_count); end
      step();
      vectors++; if (is_there_256 !== 1'b0) begin errors++; $display("FAIL s1_ready_drop got %b expected 0", is_there_256); end
   endtask

   task automatic test_overflow();
      do_reset();
      start = 1'b1;
      step();
      write_samples(0, 600);
      vectors++; if (dropped_count !== 16'd88) begin errors++; $display("FAIL s2_dropped got %0d expected 88", dropped_count); end
      vectors++; if (overflow !== 1'b1) begin errors++; $display("FAIL s2_overflow got %b expected 1", overflow); end
      vectors++; if (is_there_256 !== 1'b1) begin errors++; $display("FAIL s2_ready got %b expected 1", is_there_256); end
      rdreq = 1'b1;
      for (int i = 0; i < 512; i++) begin
         step();
         vectors++;
         if (data_blocks !== 16'(i)) begin errors++; $display("FAIL s2_data[%0d] got %0d expected %0d", i, data_blocks, i); end
         vectors++;
         if (is_there_256 !== 1'b1) begin errors++; $display("FAIL s2_ready_gap[%0d] got %b expected 1", i, is_there_256); end
      end
      rdreq = 1'b0;
      vectors++; if (frame_count !== 16'd2) begin errors++; $display("FAIL s2_frames got %0d expected 2", frame_count); end
      step();
      vectors++; if (is_there_256 !== 1'b0) begin errors++; $display("FAIL s2_ready_drop got %b expected 0", is_there_256); end
   endtask

   task automatic test_flush();
      do_reset();
      start = 1'b1;
      step();
      write_samples(0, 100);
      flush = 1'b1;
      step();
      flush = 1'b0;
      for (int p = 0; p < 156; p++) begin
         adc_valid = (p < 10);
         adc_data  = 16'hBEEF;
         step();
      end
      adc_valid = 1'b0;
      vectors++; if (is_there_256 !== 1'b0) begin errors++; $display("FAIL s3_ready_early got %b expected 0", is_there_256); end
      step();
      vectors++; if (is_there_256 !== 1'b1) begin errors++; $display("FAIL s3_ready got %b expected 1", is_there_256); end
      vectors++; if (dropped_count !== 16'd10) begin errors++; $display("FAIL s3_dropped got %0d expected 10", dropped_count); end
      vectors++; if (overflow !== 1'b0) begin errors++; $display("FAIL s3_overflow got %b expected 0", overflow); end
      for (int i = 0; i < 256; i++) begin
         rdreq = 1'b1;
         step();
         vectors++;
         if (data_blocks !== ((i < 100) ? 16'(i) : 16'h0000)) begin
            errors++;
            $display("FAIL s3_data[%0d] got %0d expected %0d", i, data_blocks, (i < 100) ? i : 0);
         end
      end
      rdreq = 1'b0;
      flush = 1'b1;
      step();
      flush = 1'b0;
      repeat (260) step();
      vectors++; if (is_there_256 !== 1'b0) begin errors++; $display("FAIL s3_empty_flush got %b expected 0", is_there_256); end
   endtask

   task automatic test_restart();
      do_reset();
      start = 1'b1;
      step();
      write_samples(500, 100);
      start = 1'b0;
      step();
      start = 1'b1;
      step();
      write_samples(1000, 256);
      step();
      vectors++; if (is_there_256 !== 1'b1) begin errors++; $display("FAIL s4_ready got %b expected 1", is_there_256); end
      for (int i = 0; i < 256; i++) begin
         rdreq = 1'b1;
         step();
         vectors++;
         if (data_blocks !== 16'(1000 + i)) begin errors++; $display("FAIL s4_data[%0d] got %0d expected %0d", i, data_blocks, 1000 + i); end
      end
      rdreq = 1'b0;
      vectors++; if (dropped_count !== 16'd0) begin errors++; $display("FAIL s4_dropped got %0d expected 0", dropped_count); end
      step();
   endtask

   task automatic test_rdreq_idle();
      rdreq = 1'b1;
      repeat (10) step();
      vectors++; if (data_blocks !== 16'd1255) begin errors++; $display("FAIL s5_hold_data got %0d expected 1255", data_blocks); end
      vectors++; if (frame_count !== 16'd1) begin errors++; $display("FAIL s5_frames got %0d expected 1", frame_count); end
      vectors++; if (is_there_256 !== 1'b0) begin errors++; $display("FAIL s5_ready got %b expected 0", is_there_256); end
      rdreq = 1'b0;
      write_samples(2000, 256);
      step();
      rdreq = 1'b1;
      step();
      vectors++; if (data_blocks !== 16'd2000) begin errors++; $display("FAIL s5_rdptr got %0d expected 2000", data_blocks); end
      repeat (255) step();
      rdreq = 1'b0;
      vectors++; if (data_blocks !== 16'd2255) begin errors++; $display("FAIL s5_last got %0d expected 2255", data_blocks); end
      vectors++; if (frame_count !== 16'd2) begin errors++; $display("FAIL s5_frames_after got %0d expected 2", frame_count); end
   endtask

   task automatic test_async_reset();
      do_reset();
      start = 1'b1;
      step();
      write_samples(0, 600);
      rdreq = 1'b1;
      repeat (20) step();
      adc_valid = 1'b1;
      adc_data  = 16'd5;
      #3;
      aclr = 1'b1;
      #1;
      vectors++; if (data_blocks !== 16'd0) begin errors++; $display("FAIL s6_data got %0d expected 0", data_blocks); end
      vectors++; if (is_there_256 !== 1'b0) begin errors++; $display("FAIL s6_ready got %b expected 0", is_there_256); end
      vectors++; if (frame_count !== 16'd0) begin errors++; $display("FAIL s6_frames got %0d expected 0", frame_count); end
      vectors++; if (dropped_count !== 16'd0) begin errors++; $display("FAIL s6_dropped got %0d expected 0", dropped_count); end
      vectors++; if (overflow !== 1'b0) begin errors++; $display("FAIL s6_overflow got %b expected 0", overflow); end
      rdreq = 1'b0; adc_valid = 1'b0; start = 1'b0;
      step();
      aclr = 1'b0;
      step();
      start = 1'b1;
      step();
      write_samples(3000, 256);
      vectors++; if (is_there_256 !== 1'b0) begin errors++; $display("FAIL s6_ready_early got %b expected 0", is_there_256); end
      step();
      vectors++; if (is_there_256 !== 1'b1) begin errors++; $display("FAIL s6_ready_latency got %b expected 1", is_there_256); end
      for (int i = 0; i < 256; i++) begin
         rdreq = 1'b1;
         step();
         vectors++;
         if (data_blocks !== 16'(3000 + i)) begin errors++; $display("FAIL s6_data[%0d] got %0d expected %0d", i, data_blocks, 3000 + i); end
      end
      rdreq = 1'b0;
      vectors++; if (frame_count !== 16'd1) begin errors++; $display("FAIL s6_frames_after got %0d expected 1", frame_count); end
      step();
      vectors++; if (is_there_256 !== 1'b0) begin errors++; $display("FAIL s6_ready_drop got %b expected 0", is_there_256); end
   endtask

   initial begin
      test_reset();
      test_single_block();
      test_overflow();
      test_flush();
      test_restart();
      test_rdreq_idle();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
